// File: rtl/i2c_tx_stream.sv
// Byte-stream I2C master transmitter: START, N ACK-checked bytes MSB-first, STOP, open-drain SCL/SDA enables.
// Optional slave clock stretching is enabled by defining I2C_TX_CLK_STRETCH_EN.
module i2c_tx_stream #(
  parameter  int unsigned QTR_DIV = 4,
  localparam int unsigned CNT_W   = $clog2(QTR_DIV + 1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  localparam logic [CNT_W-1:0] QTR_MAX = CNT_W'(QTR_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, HOLD, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] qcnt, qcnt_nxt;
  logic [1:0]       phase, phase_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       byte_r, byte_nxt;
  logic             last_r, last_nxt;
  logic             nack_r, nack_r_nxt;
  logic             got_r, got_nxt;
  logic             s_ready_nxt, busy_nxt, done_nxt, nack_nxt;
  logic             scl_oe_nxt, sda_oe_nxt;
  logic             qen, tick;

`ifdef I2C_TX_CLK_STRETCH_EN
  // Quarters with SCL released wait for the line to actually go high.
  logic scl_rel;
  assign scl_rel = ((state == START) && (phase == 2'd0)) ||
                   (((state == DATA) || (state == ACK) || (state == STOP)) && (phase == 2'd2));
  assign qen = ~(scl_rel & ~scl_in);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign qen = 1'b1;
`endif

  assign tick = qen && (qcnt == QTR_MAX);

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_nxt   = state;
    qcnt_nxt    = qcnt;
    phase_nxt   = phase;
    bit_idx_nxt = bit_idx;
    byte_nxt    = byte_r;
    last_nxt    = last_r;
    nack_r_nxt  = nack_r;
    got_nxt     = got_r;
    s_ready_nxt = 1'b0;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    nack_nxt    = 1'b0;
    scl_oe_nxt  = 1'b0;
    sda_oe_nxt  = 1'b0;

    if (qen) begin
      qcnt_nxt = tick ? '0 : qcnt + CNT_W'(1);
      if (tick) phase_nxt = phase + 2'd1;
    end

    unique case (state)
      IDLE: begin
        qcnt_nxt  = '0;
        phase_nxt = 2'd0;
        if (s_valid) begin
          byte_nxt    = s_data;
          last_nxt    = s_last;
          s_ready_nxt = 1'b1;
          busy_nxt    = 1'b1;
          nack_r_nxt  = 1'b0;
          state_nxt   = START;
        end
      end
      START: begin
        if (tick && (phase == 2'd3)) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd7;
        end
      end
      DATA: begin
        if (tick && (phase == 2'd3)) begin
          if (bit_idx == 3'd0) state_nxt = ACK;
          else                 bit_idx_nxt = bit_idx - 3'd1;
        end
      end
      ACK: begin
        if (tick && (phase == 2'd2)) nack_r_nxt = sda_in;
        if (tick && (phase == 2'd3)) begin
          if (nack_r || last_r) begin
            state_nxt = STOP;
          end else if (s_valid) begin
            byte_nxt    = s_data;
            last_nxt    = s_last;
            s_ready_nxt = 1'b1;
            bit_idx_nxt = 3'd7;
            state_nxt   = DATA;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // Byte may be taken mid-quarter; DATA starts on the next quarter boundary.
        phase_nxt = 2'd0;
        if (!got_r && s_valid) begin
          byte_nxt    = s_data;
          last_nxt    = s_last;
          s_ready_nxt = 1'b1;
          got_nxt     = 1'b1;
        end
        if (tick && (got_r || s_valid)) begin
          got_nxt     = 1'b0;
          bit_idx_nxt = 3'd7;
          state_nxt   = DATA;
        end
      end
      STOP: begin
        if (tick && (phase == 2'd3)) begin
          done_nxt  = 1'b1;
          nack_nxt  = nack_r;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line enables follow the upcoming state/quarter so they stay aligned with it.
    unique case (state_nxt)
      START: begin
        scl_oe_nxt = phase_nxt[1];
        sda_oe_nxt = (phase_nxt != 2'd0);
      end
      DATA: begin
        scl_oe_nxt = ~phase_nxt[1];
        sda_oe_nxt = ~byte_nxt[bit_idx_nxt];
      end
      ACK:  scl_oe_nxt = ~phase_nxt[1];
      HOLD: scl_oe_nxt = 1'b1;
      STOP: begin
        scl_oe_nxt = ~phase_nxt[1];
        sda_oe_nxt = (phase_nxt != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      qcnt    <= '0;
      phase   <= 2'd0;
      bit_idx <= 3'd0;
      byte_r  <= 8'd0;
      last_r  <= 1'b0;
      nack_r  <= 1'b0;
      got_r   <= 1'b0;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
      scl_oe  <= 1'b0;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nxt;
      qcnt    <= qcnt_nxt;
      phase   <= phase_nxt;
      bit_idx <= bit_idx_nxt;
      byte_r  <= byte_nxt;
      last_r  <= last_nxt;
      nack_r  <= nack_r_nxt;
      got_r   <= got_nxt;
      s_ready <= s_ready_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      nack    <= nack_nxt;
      scl_oe  <= scl_oe_nxt;
      sda_oe  <= sda_oe_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_tx_stream.sv
// Bench for i2c_tx_stream: bus-level monitor/slave model decodes START/bytes/ACK/STOP and checks against the byte plan.
module tb_i2c_tx_stream;
  localparam int unsigned QTR = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready, busy, done, nack;
  logic       scl_oe, sda_oe, scl_in, sda_in;
  logic       slave_pull, stretch_pull;

  always #5 clk = ~clk;

  // Open-drain bus: line low if anybody pulls.
  assign scl_in = ~scl_oe & ~stretch_pull;
  assign sda_in = ~sda_oe & ~slave_pull;

  i2c_tx_stream #(.QTR_DIV(QTR)) dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .busy(busy), .done(done), .nack(nack),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  int         rise_cnt, fall_cnt, start_cnt, stop_cnt, ready_cnt, done_cnt, busy_cnt;
  int         ready0_cyc, done_cyc;
  logic       done_nack;
  logic [7:0] sh;
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];
  logic       ack_plan[$];
  logic [7:0] txd[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    rise_cnt = 0; fall_cnt = 0; start_cnt = 0; stop_cnt = 0;
    ready_cnt = 0; done_cnt = 0; busy_cnt = 0; ready0_cyc = 0; done_cyc = 0;
    done_nack = 1'b0; sh = 8'd0;
    mon_bytes.delete(); mon_acks.delete();
  endtask

  // Bus decoder plus an ACKing slave that pulls SDA between the 8th and 9th SCL fall of each byte.
  task automatic mon_step();
    logic scl_l, sda_l;
    scl_l = scl_in;
    sda_l = sda_in;
    if (prev_scl && scl_l) begin
      if (prev_sda && !sda_l) begin start_cnt++; rise_cnt = 0; fall_cnt = 0; end
      else if (!prev_sda && sda_l) stop_cnt++;
    end else if (!prev_scl && scl_l) begin
      if (rise_cnt % 9 == 8) mon_acks.push_back(sda_l);
      else begin
        sh = {sh[6:0], sda_l};
        if (rise_cnt % 9 == 7) mon_bytes.push_back(sh);
      end
      rise_cnt++;
    end else if (prev_scl && !scl_l) begin
      fall_cnt++;
    end
    slave_pull = 1'b0;
    if (fall_cnt > 0 && fall_cnt % 9 == 0 && (fall_cnt / 9 - 1) < ack_plan.size())
      slave_pull = ack_plan[fall_cnt / 9 - 1];
    if (s_ready === 1'b1) begin
      if (ready_cnt == 0) ready0_cyc = cyc;
      ready_cnt++;
    end
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; done_nack = nack; end
    prev_scl = scl_l;
    prev_sda = sda_l;
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    mon_step();
  endtask

  // Send txd[] with slave acks from ack_plan[]; after each accepted byte the source idles 'gap' cycles.
  task automatic run_txn(input int gap, input int min_hold, input bit do_stretch);
    int n, idx, wait_c, budget, nsent, hold_cyc, hold_viol, ext;
`ifdef I2C_TX_CLK_STRETCH_EN
    int st_cnt;
    bit st_done;
    st_cnt = 0; st_done = 1'b0;
`endif
    n = txd.size();
    mon_clear();
    idx = 0; wait_c = 0; budget = 0; hold_cyc = 0; hold_viol = 0;
    ext = do_stretch ? 10 : 0;
    s_data = txd[0]; s_last = (n == 1); s_valid = 1'b1;
    while (done_cnt == 0 && budget < 4000) begin
      step();
      budget++;
      if (!s_valid && idx > 0 && idx < n && ack_plan[idx-1] && fall_cnt == 9 * idx + 1) begin
        hold_cyc++;
        if (scl_oe !== 1'b1 || sda_oe !== 1'b0) hold_viol++;
      end
      if (s_ready === 1'b1) begin
        idx++;
        if (idx < n) begin
          if (gap == 0) begin s_data = txd[idx]; s_last = (idx == n - 1); s_valid = 1'b1; end
          else begin s_valid = 1'b0; wait_c = gap; end
        end else s_valid = 1'b0;
      end else if (wait_c > 0) begin
        wait_c--;
        if (wait_c == 0) begin s_data = txd[idx]; s_last = (idx == n - 1); s_valid = 1'b1; end
      end
`ifdef I2C_TX_CLK_STRETCH_EN
      if (do_stretch && !st_done) begin
        if (!stretch_pull && rise_cnt == 2 && scl_oe === 1'b1) stretch_pull = 1'b1;
        else if (stretch_pull && scl_oe === 1'b0) begin
          if (st_cnt == 10) begin stretch_pull = 1'b0; st_done = 1'b1; end
          else st_cnt++;
        end
      end
`endif
    end
    s_valid = 1'b0;
    nsent = n;
    for (int i = n - 1; i >= 0; i--) if (!ack_plan[i]) nsent = i + 1;
    check("done_seen", done_cnt, 1);
    check("ready_count", ready_cnt, nsent);
    check("start_count", start_cnt, 1);
    check("stop_count", stop_cnt, 1);
    check("byte_count", mon_bytes.size(), nsent);
    for (int i = 0; i < nsent; i++) begin
      if (i < mon_bytes.size()) check("byte_value", mon_bytes[i], txd[i]);
      if (i < mon_acks.size())  check("ack_bit", mon_acks[i], !ack_plan[i]);
    end
    check("nack_flag", done_nack, !ack_plan[nsent-1]);
    check("busy_span", busy_cnt, done_cyc - ready0_cyc);
    check("hold_lines", hold_viol, 0);
    if (min_hold > 0) check("hold_length", hold_cyc >= min_hold, 1);
    if (gap == 0 || nsent == 1) check("latency", done_cyc - ready0_cyc, (8 + 36 * nsent) * QTR + ext);
    step();
    check("done_single", {done, busy}, 0);
  endtask

  initial begin
    int b, d1;
    rstn = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0;
    slave_pull = 1'b0; stretch_pull = 1'b0;
    mon_clear();
    repeat (3) step();
    check("reset_state", {scl_oe, sda_oe, s_ready, busy, done, nack}, 0);
    rstn = 1'b1;
    step();

    // Single byte, acked.
    txd.delete(); ack_plan.delete();
    txd.push_back(8'hA5); ack_plan.push_back(1'b1);
    run_txn(0, 0, 1'b0);

    // Two bytes streamed without a gap.
    txd.delete(); ack_plan.delete();
    txd.push_back(8'h50); txd.push_back(8'h3C);
    ack_plan.push_back(1'b1); ack_plan.push_back(1'b1);
    run_txn(0, 0, 1'b0);

    // NACK on first byte; second byte must stay unconsumed.
    txd.delete(); ack_plan.delete();
    txd.push_back(8'h90); txd.push_back(8'h11);
    ack_plan.push_back(1'b0); ack_plan.push_back(1'b1);
    run_txn(0, 0, 1'b0);

    // Source stalls ~20 cycles past the first ACK: HOLD.
    txd.delete(); ack_plan.delete();
    txd.push_back(8'h6E); txd.push_back(8'h81);
    ack_plan.push_back(1'b1); ack_plan.push_back(1'b1);
    run_txn(100, 20, 1'b0);

`ifdef I2C_TX_CLK_STRETCH_EN
    txd.delete(); ack_plan.delete();
    txd.push_back(8'hA5); ack_plan.push_back(1'b1);
    run_txn(0, 0, 1'b1);
`endif

    // Back-to-back: s_valid held through done, next START after one IDLE cycle.
    txd.delete(); ack_plan.delete();
    ack_plan.push_back(1'b1);
    mon_clear();
    s_data = 8'hC3; s_last = 1'b1; s_valid = 1'b1;
    b = 0;
    while (done_cnt == 0 && b < 2000) begin
      step(); b++;
      if (s_ready === 1'b1) s_data = 8'h3C;
    end
    check("b2b_done1", done_cnt, 1);
    d1 = done_cyc;
    step();
    check("b2b_accept", s_ready, 1);
    s_valid = 1'b0; done_cnt = 0; b = 0;
    while (done_cnt == 0 && b < 2000) begin step(); b++; end
    check("b2b_done2", done_cnt, 1);
    check("b2b_latency", done_cyc - d1 - 1, 44 * QTR);
    check("b2b_bytes", mon_bytes.size(), 2);
    if (mon_bytes.size() > 1) check("b2b_byte2", mon_bytes[1], 8'h3C);
    step();

    // Randomised transactions.
    for (int t = 0; t < 12; t++) begin
      int n, gap;
      n = $urandom_range(1, 4);
      gap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 40)) : 0;
      txd.delete(); ack_plan.delete();
      for (int i = 0; i < n; i++) begin
        txd.push_back(8'($urandom));
        ack_plan.push_back($urandom_range(0, 4) != 0);
      end
      run_txn(gap, 0, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    // Reset during bit 4 of a byte: lines released at once, no STOP, no done.
    txd.delete(); ack_plan.delete();
    ack_plan.push_back(1'b1);
    mon_clear();
    s_data = 8'h5A; s_last = 1'b1; s_valid = 1'b1;
    b = 0;
    while (rise_cnt < 4 && b < 500) begin
      step(); b++;
      if (s_ready === 1'b1) s_valid = 1'b0;
    end
    check("rst_reach_bit4", rise_cnt, 4);
    rstn = 1'b0;
    step();
    check("rst_lines", {scl_oe, sda_oe, busy, s_ready}, 0);
    rstn = 1'b1;
    repeat (20) step();
    check("rst_no_done", done_cnt, 0);
    check("rst_no_stop", stop_cnt, 0);
    check("rst_idle", {scl_oe, sda_oe, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
